// File: rtl/picomips_io_pkg.sv
// Shared types and constants for the picoMIPS operator switch/LED responder.
package picomips_io_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int SW_GO_BIT      = 8;

    typedef enum logic [2:0] {
        WAIT_LOW    = 3'd0,
        ARMED       = 3'd1,
        CAPTURED    = 3'd2,
        WAIT_RESULT = 3'd3,
        SHOW        = 3'd4
    } io_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Single-bit synchroniser followed by a stability counter; q only follows d
// after it has held a new value for DEBOUNCE_CYCLES synchronised cycles.
module sw_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   s_bit;

    assign s_bit = sync_q[SYNC_STAGES-1];
    assign q     = deb_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        cnt_d  = '0;
        deb_d  = deb_q;
        if (s_bit != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = s_bit;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

endmodule

// File: rtl/sw_led_io.sv
// Operator I/O responder: captures a switch index on a debounced SW[8] rise,
// hands it to the CPU with valid/ack, and shows the CPU result on LED.
module sw_led_io
    import picomips_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DATA_W          = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        SW,
    output logic [7:0]        LED,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    input  logic              in_ack,
    input  logic              out_wr,
    input  logic [DATA_W-1:0] out_data,
    output logic [2:0]        io_state
);

    // The debounce pipeline needs this many edges before deb8 reflects the switch.
    localparam int SETTLE   = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    logic                         deb8, deb8_q, deb8_d;
    logic                         rise8, fall8;
    logic [SYNC_STAGES-1:0][7:0]  idx_sync_q, idx_sync_d;
    logic [7:0]                   s_idx;
    logic [SETTLE_W-1:0]          settle_q, settle_d;
    logic                         settled;
    io_state_t                    state_q, state_d;
    logic [7:0]                   led_q, led_d;
    logic [DATA_W-1:0]            in_data_q, in_data_d;
    logic                         in_valid_q, in_valid_d;

    sw_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_go_debounce (
        .clk  (clk),
        .reset(reset),
        .d    (SW[SW_GO_BIT]),
        .q    (deb8)
    );

    assign s_idx    = idx_sync_q[SYNC_STAGES-1];
    assign rise8    = deb8 & ~deb8_q;
    assign fall8    = ~deb8 & deb8_q;
    assign settled  = (settle_q == SETTLE_W'(SETTLE));
    assign LED      = led_q;
    assign in_data  = in_data_q;
    assign in_valid = in_valid_q;
    assign io_state = state_q;

    always_comb begin
        idx_sync_d    = idx_sync_q;
        idx_sync_d[0] = SW[SW_GO_BIT-1:0];
        for (int i = 1; i < SYNC_STAGES; i++) begin
            idx_sync_d[i] = idx_sync_q[i-1];
        end
        deb8_d = deb8;
        if (settled) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + SETTLE_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOW:    if (settled && !deb8) state_d = ARMED;       else state_d = WAIT_LOW;
            ARMED:       if (rise8)            state_d = CAPTURED;    else state_d = ARMED;
            CAPTURED:    if (in_ack)           state_d = WAIT_RESULT; else state_d = CAPTURED;
            WAIT_RESULT: if (out_wr)           state_d = SHOW;        else state_d = WAIT_RESULT;
            SHOW:        if (fall8)            state_d = ARMED;       else state_d = SHOW;
            default:                           state_d = WAIT_LOW;
        endcase
    end

    // LED accepts a CPU write in any state; valid/data only move on capture and ack.
    always_comb begin
        if (out_wr) begin
            led_d = 8'(out_data);
        end else begin
            led_d = led_q;
        end
        in_data_d  = in_data_q;
        in_valid_d = in_valid_q;
        case (state_q)
            ARMED: begin
                if (rise8) begin
                    in_data_d  = DATA_W'(s_idx);
                    in_valid_d = 1'b1;
                end else begin
                    in_valid_d = in_valid_q;
                end
            end
            CAPTURED: begin
                if (in_ack) begin
                    in_valid_d = 1'b0;
                end else begin
                    in_valid_d = in_valid_q;
                end
            end
            WAIT_LOW, WAIT_RESULT, SHOW: in_valid_d = in_valid_q;
            default:                     in_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_sync_q <= '0;
            deb8_q     <= 1'b0;
            settle_q   <= '0;
            state_q    <= WAIT_LOW;
            led_q      <= 8'h00;
            in_data_q  <= '0;
            in_valid_q <= 1'b0;
        end else begin
            idx_sync_q <= idx_sync_d;
            deb8_q     <= deb8_d;
            settle_q   <= settle_d;
            state_q    <= state_d;
            led_q      <= led_d;
            in_data_q  <= in_data_d;
            in_valid_q <= in_valid_d;
        end
    end

endmodule

// File: tb/tb_sw_led_io.sv
// Directed self-checking bench for sw_led_io with default parameters.
module tb_sw_led_io;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] SW;
    logic [7:0] LED;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ack;
    logic       out_wr;
    logic [7:0] out_data;
    logic [2:0] io_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sw_led_io dut (
        .clk     (clk),
        .reset   (reset),
        .SW      (SW),
        .LED     (LED),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ack  (in_ack),
        .out_wr  (out_wr),
        .out_data(out_data),
        .io_state(io_state)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; SW = 9'h1FF; in_ack = 1'b0; out_wr = 1'b0; out_data = 8'h00;
        tick(3);
        n_cmp++;
        if ({LED, in_valid, io_state} !== {8'h00, 1'b0, 3'd0}) begin
            n_bad++; $display("FAIL reset_hold: LED=%h in_valid=%b io_state=%0d expected 00/0/0", LED, in_valid, io_state);
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            n_cmp++;
            if ({LED, in_valid, io_state} !== {8'h00, 1'b0, 3'd0}) begin
                n_bad++; $display("FAIL sw8_high_after_reset cycle %0d: LED=%h in_valid=%b io_state=%0d expected 00/0/0", i, LED, in_valid, io_state);
            end
        end
    endtask

    task automatic test_arm();
        SW = 9'h014;
        tick(20);
        n_cmp++;
        if ({in_valid, io_state} !== {1'b0, 3'd1}) begin
            n_bad++; $display("FAIL arm: in_valid=%b io_state=%0d expected 0/1", in_valid, io_state);
        end
    endtask

    task automatic test_glitch();
        for (int len = 2; len <= 3; len++) begin
            SW = 9'h114;
            tick(len);
            SW = 9'h014;
            for (int i = 0; i < 15; i++) begin
                tick(1);
                n_cmp++;
                if ({in_valid, io_state} !== {1'b0, 3'd1}) begin
                    n_bad++; $display("FAIL glitch_len%0d cycle %0d: in_valid=%b io_state=%0d expected 0/1", len, i, in_valid, io_state);
                end
            end
        end
    endtask

    task automatic test_ack_outside();
        in_ack = 1'b1; tick(1); in_ack = 1'b0;
        n_cmp++;
        if ({in_valid, io_state} !== {1'b0, 3'd1}) begin
            n_bad++; $display("FAIL ack_in_armed: in_valid=%b io_state=%0d expected 0/1", in_valid, io_state);
        end
        out_wr = 1'b1; out_data = 8'h33; tick(1); out_wr = 1'b0;
        n_cmp++;
        if ({LED, io_state} !== {8'h33, 3'd1}) begin
            n_bad++; $display("FAIL wr_in_armed: LED=%h io_state=%0d expected 33/1", LED, io_state);
        end
    endtask

    task automatic test_capture();
        SW = 9'h114;
        tick(6);
        n_cmp++;
        if ({in_valid, io_state} !== {1'b0, 3'd1}) begin
            n_bad++; $display("FAIL capture_edge6: in_valid=%b io_state=%0d expected 0/1", in_valid, io_state);
        end
        tick(1);
        n_cmp++;
        if ({in_valid, in_data, io_state} !== {1'b1, 8'h14, 3'd2}) begin
            n_bad++; $display("FAIL capture_edge7: in_valid=%b in_data=%h io_state=%0d expected 1/14/2", in_valid, in_data, io_state);
        end
    endtask

    task automatic test_index_hold();
        SW = 9'h1FF;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_cmp++;
            if ({in_valid, in_data, io_state} !== {1'b1, 8'h14, 3'd2}) begin
                n_bad++; $display("FAIL index_hold cycle %0d: in_valid=%b in_data=%h io_state=%0d expected 1/14/2", i, in_valid, in_data, io_state);
            end
        end
    endtask

    task automatic test_handshake();
        in_ack = 1'b1; tick(1); in_ack = 1'b0;
        n_cmp++;
        if ({in_valid, io_state} !== {1'b0, 3'd3}) begin
            n_bad++; $display("FAIL ack: in_valid=%b io_state=%0d expected 0/3", in_valid, io_state);
        end
        out_wr = 1'b1; out_data = 8'h5A; tick(1); out_wr = 1'b0;
        n_cmp++;
        if ({LED, io_state} !== {8'h5A, 3'd4}) begin
            n_bad++; $display("FAIL result_wr: LED=%h io_state=%0d expected 5a/4", LED, io_state);
        end
        SW = 9'h0FF;
        tick(6);
        n_cmp++;
        if (io_state !== 3'd4) begin
            n_bad++; $display("FAIL release_edge6: io_state=%0d expected 4", io_state);
        end
        tick(1);
        n_cmp++;
        if ({LED, io_state} !== {8'h5A, 3'd1}) begin
            n_bad++; $display("FAIL release_edge7: LED=%h io_state=%0d expected 5a/1", LED, io_state);
        end
    endtask

    task automatic test_back_to_back();
        SW = 9'h121;
        tick(7);
        n_cmp++;
        if ({in_valid, in_data, io_state} !== {1'b1, 8'h21, 3'd2}) begin
            n_bad++; $display("FAIL recapture: in_valid=%b in_data=%h io_state=%0d expected 1/21/2", in_valid, in_data, io_state);
        end
        SW = 9'h021;
        tick(12);
        n_cmp++;
        if ({in_valid, io_state} !== {1'b1, 3'd2}) begin
            n_bad++; $display("FAIL drop_in_captured: in_valid=%b io_state=%0d expected 1/2", in_valid, io_state);
        end
        in_ack = 1'b1; out_wr = 1'b1; out_data = 8'h77; tick(1); in_ack = 1'b0; out_wr = 1'b0;
        n_cmp++;
        if ({LED, in_valid, io_state} !== {8'h77, 1'b0, 3'd3}) begin
            n_bad++; $display("FAIL ack_and_wr: LED=%h in_valid=%b io_state=%0d expected 77/0/3", LED, in_valid, io_state);
        end
        out_wr = 1'b1; out_data = 8'h5A; tick(1); out_wr = 1'b0;
        n_cmp++;
        if ({LED, io_state} !== {8'h5A, 3'd4}) begin
            n_bad++; $display("FAIL second_result: LED=%h io_state=%0d expected 5a/4", LED, io_state);
        end
        SW = 9'h121;
        tick(12);
        n_cmp++;
        if (io_state !== 3'd4) begin
            n_bad++; $display("FAIL rise_in_show: io_state=%0d expected 4", io_state);
        end
        SW = 9'h021;
        tick(7);
        n_cmp++;
        if (io_state !== 3'd1) begin
            n_bad++; $display("FAIL rearm: io_state=%0d expected 1", io_state);
        end
        SW = 9'h13C;
        tick(7);
        n_cmp++;
        if ({LED, in_valid, in_data, io_state} !== {8'h5A, 1'b1, 8'h3C, 3'd2}) begin
            n_bad++; $display("FAIL third_capture: LED=%h in_valid=%b in_data=%h io_state=%0d expected 5a/1/3c/2", LED, in_valid, in_data, io_state);
        end
    endtask

    task automatic test_reset_midop();
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({LED, in_valid, in_data, io_state} !== {8'h00, 1'b0, 8'h00, 3'd0}) begin
            n_bad++; $display("FAIL async_reset: LED=%h in_valid=%b in_data=%h io_state=%0d expected 00/0/00/0", LED, in_valid, in_data, io_state);
        end
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arm();
        test_glitch();
        test_ack_outside();
        test_capture();
        test_index_hold();
        test_handshake();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
